// File: rtl/ex_div_ctrl.sv
// EX-stage divider sequencer: 32-step restoring DIV/DIVU with divide-by-zero,
// sign correction and annul handling. The stall request is derived from the registered div_ready.
module ex_div_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        div_start,
  input  logic        div_signed,
  input  logic [31:0] div_op1,
  input  logic [31:0] div_op2,
  input  logic        div_annul,
  output logic [63:0] div_result,
  output logic        div_ready,
  output logic        stallreq_div
);

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 6;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_DIVZERO = 2'd1;
  localparam logic [1:0] S_ON      = 2'd2;
  localparam logic [1:0] S_END     = 2'd3;

  logic [1:0]      r_state;
  logic [1:0]      w_next;
  logic [2*DW:0]   r_w;
  logic [DW-1:0]   r_d;
  logic [CW-1:0]   r_cnt;
  logic            r_s1;
  logic            r_s2;

  logic            w_accept;
  logic            w_s1;
  logic            w_s2;
  logic [DW-1:0]   w_abs1;
  logic [DW-1:0]   w_abs2;
  logic [DW:0]     w_trial;
  logic [DW-1:0]   w_q;
  logic [DW-1:0]   w_r;

  // Operand magnitudes; 0x80000000 negates to itself and is then read as unsigned.
  assign w_accept = div_start & ~div_annul;
  assign w_s1     = div_signed & div_op1[DW-1];
  assign w_s2     = div_signed & div_op2[DW-1];
  assign w_abs1   = w_s1 ? DW'(~div_op1 + 32'd1) : div_op1;
  assign w_abs2   = w_s2 ? DW'(~div_op2 + 32'd1) : div_op2;

  assign w_trial  = {1'b0, r_w[2*DW-1:DW]} - {1'b0, r_d};
  // Quotient sign is the XOR of operand signs; remainder follows the dividend.
  assign w_q      = (r_s1 ^ r_s2) ? DW'(~r_w[DW-1:0] + 32'd1) : r_w[DW-1:0];
  assign w_r      = r_s1 ? DW'(~r_w[2*DW:DW+1] + 32'd1) : r_w[2*DW:DW+1];

  assign stallreq_div = div_start & ~div_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_accept) w_next = (div_op2 == '0) ? S_DIVZERO : S_ON;
      S_DIVZERO: w_next = S_END;
      S_ON:      if (r_cnt == CW'(DW)) w_next = S_END;
      S_END:     if (!div_start) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
    if (div_annul) w_next = S_IDLE;
  end

  // Datapath and registered outputs; annul leaves div_result untouched.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_w        <= '0;
      r_d        <= '0;
      r_cnt      <= '0;
      r_s1       <= 1'b0;
      r_s2       <= 1'b0;
      div_result <= '0;
      div_ready  <= 1'b0;
    end else if (div_annul && (r_state != S_IDLE)) begin
      r_cnt     <= '0;
      div_ready <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_s1 <= w_s1;
            r_s2 <= w_s2;
            if (div_op2 != '0) begin
              r_cnt <= '0;
              r_d   <= w_abs2;
              r_w   <= {32'b0, w_abs1, 1'b0};
            end
          end
        end
        S_DIVZERO: begin
          div_result <= '0;
          div_ready  <= 1'b1;
        end
        S_ON: begin
          if (r_cnt < CW'(DW)) begin
            if (w_trial[DW]) r_w <= {r_w[2*DW-1:0], 1'b0};
            else             r_w <= {w_trial[DW-1:0], r_w[DW-1:0], 1'b1};
            r_cnt <= r_cnt + CW'(1);
          end else begin
            div_result <= {w_r, w_q};
            div_ready  <= 1'b1;
          end
        end
        S_END: begin
          if (!div_start) div_ready <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_div_ctrl.sv
// Directed bench for ex_div_ctrl: latency, signed/unsigned results, divide-by-zero,
// annul, asynchronous reset and operand isolation after acceptance.
module tb_ex_div_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        div_start;
  logic        div_signed;
  logic [31:0] div_op1;
  logic [31:0] div_op2;
  logic        div_annul;
  logic [63:0] div_result;
  logic        div_ready;
  logic        stallreq_div;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ex_div_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .div_start    (div_start),
    .div_signed   (div_signed),
    .div_op1      (div_op1),
    .div_op2      (div_op2),
    .div_annul    (div_annul),
    .div_result   (div_result),
    .div_ready    (div_ready),
    .stallreq_div (stallreq_div)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp_res,
                         input int exp_lat, input bit scramble);
    int n;
    int stalls;
    n = 0;
    stalls = 0;
    div_signed = sgn;
    div_op1    = a;
    div_op2    = b;
    div_start  = 1'b1;
    do begin
      @(posedge clk);
      @(negedge clk);
      n++;
      if (stallreq_div) stalls++;
      if (scramble && n == 1) begin
        div_op1    = $urandom;
        div_op2    = $urandom;
        div_signed = ~sgn;
      end
    end while (!div_ready && n < 100);
    check({tag, " latency"}, 64'(n - 1), 64'(exp_lat));
    check({tag, " result"}, div_result, exp_res);
    check({tag, " stall_cycles"}, 64'(stalls), 64'(exp_lat));
    @(posedge clk);
    @(negedge clk);
    check({tag, " end_hold"}, {div_result, 63'(div_ready)}, {exp_res, 63'd1});
    div_start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check({tag, " ready_drop"}, 64'(div_ready), 64'd0);
    check({tag, " stall_drop"}, 64'(stallreq_div), 64'd0);
  endtask

  initial begin
    bit rose;
    rst        = 1'b0;
    div_start  = 1'b0;
    div_signed = 1'b0;
    div_op1    = '0;
    div_op2    = '0;
    div_annul  = 1'b0;
    #1;
    check("reset result", div_result, 64'd0);
    check("reset ready", 64'(div_ready), 64'd0);
    check("reset stall", 64'(stallreq_div), 64'd0);
    div_start = 1'b1;
    #1;
    check("reset stall_follows_start", 64'(stallreq_div), 64'd1);
    div_start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    run_div("divu 100/7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33, 1'b0);
    run_div("div -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33, 1'b0);
    run_div("div 7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD}, 33, 1'b0);
    run_div("divu fff9/2", 1'b0, 32'hFFFF_FFF9, 32'd2, {32'd1, 32'h7FFF_FFFC}, 33, 1'b0);
    run_div("div by zero", 1'b1, 32'd1234, 32'd0, 64'd0, 1, 1'b0);
    run_div("div ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 33, 1'b0);
    run_div("divu max/1", 1'b0, 32'hFFFF_FFFF, 32'd1, {32'd0, 32'hFFFF_FFFF}, 33, 1'b0);

    // Annul at ON cycle 10: aborted op never reports ready.
    div_signed = 1'b0;
    div_op1    = 32'd1000;
    div_op2    = 32'd7;
    div_start  = 1'b1;
    repeat (11) @(posedge clk);
    @(negedge clk);
    div_annul = 1'b1;
    div_start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    div_annul = 1'b0;
    check("annul ready", 64'(div_ready), 64'd0);
    check("annul stall", 64'(stallreq_div), 64'd0);
    rose = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (div_ready) rose = 1'b1;
    end
    check("annul never_ready", 64'(rose), 64'd0);
    run_div("post-annul 9/3", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33, 1'b0);

    // Annul together with start in IDLE is not accepted.
    div_op1   = 32'd20;
    div_op2   = 32'd4;
    div_start = 1'b1;
    div_annul = 1'b1;
    @(posedge clk);
    @(negedge clk);
    div_start = 1'b0;
    div_annul = 1'b0;
    rose = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (div_ready) rose = 1'b1;
    end
    check("idle annul not_accepted", 64'(rose), 64'd0);

    // Asynchronous reset at ON cycle 20, between edges.
    div_op1   = 32'd1000;
    div_op2   = 32'd3;
    div_start = 1'b1;
    repeat (21) @(posedge clk);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("async rst result", div_result, 64'd0);
    check("async rst ready", 64'(div_ready), 64'd0);
    check("async rst stall_follows_start", 64'(stallreq_div), 64'd1);
    div_start = 1'b0;
    #1;
    check("async rst stall", 64'(stallreq_div), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run_div("post-rst 50/5 scrambled", 1'b0, 32'd50, 32'd5, {32'd0, 32'd10}, 33, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_div_ctrl.md
# ex_div_ctrl

Multi-cycle divider sequencer attached to the EX stage. It accepts DIV/DIVU operands from EX and runs a 32-iteration restoring division. While the operation is in flight it raises a stall request to the pipeline controller, then returns the 64-bit {remainder, quotient} pair for the HI/LO write path. It also handles divide-by-zero, signed correction and flush (annul) of an in-flight operation.

## Interface
- No parameters; the data width is fixed at 32.
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  active-low asynchronous reset.
- div_start  in  1  EX requests a divide; held high until div_ready is seen.
- div_signed  in  1  1 = DIV (signed), 0 = DIVU; sampled with div_start.
- div_op1  in  32  dividend; sampled at acceptance only.
- div_op2  in  32  divisor; sampled at acceptance only.
- div_annul  in  1  flush; aborts any operation and returns to IDLE.
- div_result  out  32+32=64  [63:32] remainder, [31:0] quotient.
- div_ready  out  1  result valid.
- stallreq_div  out  1  stall request into the StallBus controller.

## Operation
- States: IDLE, DIVZERO, ON, END. Reset state is IDLE.
- Internal registers:
  - 65-bit work register W.
  - 32-bit divisor D.
  - 6-bit counter cnt.
  - Latched sign flags s1 = op1[31] & signed and s2 = op2[31] & signed.
- IDLE, when div_start=1 and div_annul=0:
  - If div_op2 = 0, go to DIVZERO.
  - Otherwise go to ON with cnt = 0, D = |op2|, and W = {32'b0, |op1|, 1'b0}.
  - |x| is the two's-complement negation when the corresponding s flag is set; else x unchanged. 0x80000000 stays 0x80000000, interpreted unsigned.
- IDLE otherwise: hold.
- ON step, when cnt < 32:
  - Trial subtraction: T = {1'b0, W[63:32]} − {1'b0, D}, 33 bits.
  - If T[32] = 1, then W ← W << 1.
  - Else W ← {T[31:0], W[31:0], 1'b1}.
  - In both cases cnt ← cnt + 1.
- ON finish, when cnt = 32:
  - q = W[31:0] and r = W[64:33].
  - Quotient is negated if s1 ^ s2.
  - Remainder is negated if s1, so it takes the dividend's sign.
  - div_result ← {r', q'}, div_ready ← 1, go to END.
- DIVZERO: div_result ← 64'b0, div_ready ← 1, go to END.
- END:
  - If div_start = 0, go to IDLE and div_ready ← 0.
  - Else hold END; div_result is held stable.
- div_annul = 1 in any state except IDLE: next state IDLE, div_ready ← 0, cnt ← 0. div_result keeps its last value.
- div_annul = 1 together with div_start in IDLE: the request is not accepted.
- stallreq_div = div_start & ~div_ready. This output is combinational from registered div_ready.
- Arithmetic:
  - Signed overflow 0x80000000 / 0xFFFFFFFF wraps to q = 0x80000000, r = 0.
  - All results are modulo 2^32.

## Timing
- Reset (rst = 0, asynchronous) gives: state IDLE, div_result = 0, div_ready = 0, cnt = 0, W = 0, D = 0. stallreq_div then follows div_start.
- Reset asserted mid-operation aborts immediately. There is no partial result and div_ready stays 0.
- Normal divide latency, counting from edge E0 where div_start is first sampled in IDLE:
  - E0 enters ON.
  - E1..E32 perform the 32 steps.
  - E33 latches the result.
  - div_ready is high from E33 onward: 33 cycles of stall after E0.
- Divide-by-zero: E0 → DIVZERO, E1 → END; div_ready is high after E1.
- div_ready drops on the first edge in END that samples div_start = 0.
- A new request needs at least one cycle back in IDLE, so back-to-back ops have a one-cycle bubble.
- Operand changes after E0 have no effect.
- div_annul takes effect at the next edge. stallreq_div deasserts once the requester drops div_start.

## Test plan
- Unsigned 100 / 7, held start → div_ready rises 33 edges after E0; div_result = {32'd2, 32'd14}; stallreq_div high for exactly 33 cycles with start held.
- Signed 0xFFFFFFF9 / 2 (−7/2) → q = 0xFFFFFFFD, r = 0xFFFFFFFF. Signed 7 / 0xFFFFFFFE → q = 0xFFFFFFFD, r = 1. The same bits via DIVU give q = 0x7FFFFFFC, r = 1.
- Divisor 0 → div_ready after E1, div_result = 0. Drop start → IDLE next edge, div_ready = 0.
- Signed 0x80000000 / 0xFFFFFFFF → q = 0x80000000, r = 0. Unsigned 0xFFFFFFFF / 1 → q = 0xFFFFFFFF, r = 0.
- Assert div_annul at cycle 10 of ON → IDLE next edge, div_ready never rises. A fresh 9/3 afterwards → q = 3, r = 0 at normal latency.
- Pull rst low mid-ON (cycle 20), asynchronously between edges → all outputs 0 immediately. Release and issue 50/5 → q = 10, r = 0. Changing div_op1/op2 after E0 does not alter the result.
